spike_event_encoder: RTL and testbench
======================================

# spike_event_encoder

Downstream consumer of the SNN core's per-timestep `output_spikes` vector. On each timestep strobe it latches the 8-bit spike vector and scans it LSB-first. Every set bit becomes one address-event word `{marker, timestep, neuron_id}`, which is buffered in a FIFO and drained through a valid/ready port. This port feeds the readout path, so the host receives a compact event stream instead of raw vectors.

## Interface
- `FIFO_DEPTH`, default 16: event FIFO entries; must be a power of 2, ≥ 2.
- `clk`  in  1: system clock; the only clock in the block.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: when low, `step_strobe` is ignored and the timestep counter holds. A scan already in progress still completes.
- `step_strobe`  in  1: one-cycle pulse marking the end of an SNN timestep.
- `spikes_in`  in  8: output spike vector; sampled only on an accepted strobe.
- `out_data`  out  12: event word `{marker[11], timestep[10:3], neuron_id[2:0]}`; driven by the FIFO head.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: consumer accepts the head word when `out_valid & out_ready`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current occupancy.
- `busy`  out  1: high in SCAN or while the pending buffer is full.
- `overflow`  out  1: sticky; set when an event was dropped because the FIFO was full.
- `step_lost`  out  1: sticky; set when a strobe arrived while both the scan and pending slots were occupied.
- `clear_flags`  in  1: synchronous clear of `overflow` and `step_lost`.

## Operation
- Reset values:
  - all outputs 0; `out_data` = 0.
  - FIFO empty.
  - timestep counter `ts` = 0.
  - state IDLE; pending slot empty.
- Accepted strobe (`step_strobe & enable`):
  - capture `{spikes_in, ts}` as a step record.
  - `ts <= ts + 1`, 8-bit, wraps 255 → 0.
  - The record carries the pre-increment `ts`.
- States:
  - IDLE: on an accepted strobe → SCAN with the record loaded and `idx` = 0.
  - SCAN: exactly 8 cycles, `idx` 0..7, one bit per cycle. Zero bits consume a cycle but push nothing. A set bit pushes `{1'b0, ts_rec, idx}`. After `idx` = 7:
    - if the pending slot is full → load the pending record, stay in SCAN, `idx` = 0.
    - else → IDLE.
- Strobe during SCAN:
  - pending slot empty → store the record there.
  - pending slot full → discard the record, set `step_lost`. `ts` still increments.
- Strobe coinciding with the final SCAN cycle while pending is empty: the record goes straight to SCAN, with no IDLE gap.
- FIFO full on push: drop the event and set `overflow`. A simultaneous pop in the same cycle frees a slot, so the push is accepted.
- Push and pop in the same cycle: `fifo_count` is unchanged.
- `clear_flags` together with a new set condition: the set wins.
- `reset` mid-scan: the scan is aborted, FIFO flushed, pending slot cleared, `ts` = 0.

## Timing
- Strobe sampled at edge k.
- Bit `i` is evaluated and pushed at edge k+1+i.
- Event for bit 0 appears on `out_valid`/`out_data` after edge k+1, i.e. 1-cycle latency from the strobe edge to visibility. The FIFO is show-ahead and registered.
- Back-to-back strobes every 8 cycles sustain with no loss.
- The pending slot absorbs one extra strobe.
- Pop: head advances at the edge where `out_valid & out_ready`. The next word is valid in the following cycle; there is no bubble when more entries remain.
- `fifo_count` is registered and reflects pushes and pops of the previous edge.
- `busy` rises the cycle after an accepted strobe and falls the cycle after the last SCAN cycle with no pending record.

## Configuration
- `SPIKE_ENC_EMPTY_STEP_EN` defined:
  - a scan that finds no set bit pushes one marker word `{1'b1, ts_rec, 3'b000}` at the final scan cycle (k+8).
  - the marker is subject to the same overflow rule as any event.
- Undefined:
  - all-zero vectors produce no words.
  - bit 11 of `out_data` is always 0.

## Test plan
- Reset, then strobe with `spikes_in` = 8'b1000_0101 and `out_ready` = 1 → words 0x000, 0x002, 0x007 (`ts` = 0, ids 0, 2, 7); `busy` high for 8 cycles; `fifo_count` returns to 0.
- 256 strobes every 10 cycles with `spikes_in` = 8'h01 → `ts` field runs 0..255, and the 257th strobe carries `ts` = 0 (wrap).
- `out_ready` = 0, `FIFO_DEPTH` = 16, three strobes of 8'hFF → 16 words stored, 8 dropped, `overflow` = 1; `clear_flags` → 0. Draining then yields ids in order 0..7, 0..7.
- Three strobes 2 cycles apart → first two scanned back-to-back (16 SCAN cycles), third discarded, `step_lost` = 1; next step's `ts` = 3.
- Strobe with 8'h00: no output without `SPIKE_ENC_EMPTY_STEP_EN`; word 0x800 | (ts<<3) at k+8 with it. `reset` asserted mid-scan → `out_valid` = 0 and `ts` = 0 next cycle.

Source files
------------

// File: rtl/spike_event_encoder.sv
// Scans each accepted 8-bit spike vector LSB-first and emits one {marker, timestep, neuron_id} word per set bit.
// Optional: define SPIKE_ENC_EMPTY_STEP_EN to emit a marker word for timesteps with no spikes.
module spike_event_encoder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          step_strobe,
    input  logic [7:0]                    spikes_in,
    output logic [11:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          step_lost,
    input  logic                          clear_flags
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t         state;
    logic [7:0]     ts;
    logic [7:0]     scan_vec;
    logic [7:0]     scan_ts;
    logic [2:0]     idx;
    logic           pend_full;
    logic [7:0]     pend_vec;
    logic [7:0]     pend_ts;

    logic           strobe_ok;
    logic           last_cycle;
    logic           lost_set;
    logic           push_req;
    logic [11:0]    push_data;

    logic [11:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           pop;
    logic           push_ok;
    logic           overflow_set;

    assign strobe_ok  = step_strobe & enable;
    assign last_cycle = (state == SCAN) && (idx == 3'd7);
    // A strobe on the final scan cycle never counts as lost: the pending slot drains that same edge.
    assign lost_set   = strobe_ok && (state == SCAN) && !last_cycle && pend_full;

    always_comb begin
        push_req  = 1'b0;
        push_data = '0;
        if (state == SCAN) begin
            if (scan_vec[idx]) begin
                push_req  = 1'b1;
                push_data = {1'b0, scan_ts, idx};
            end
`ifdef SPIKE_ENC_EMPTY_STEP_EN
            else if (last_cycle && (scan_vec == 8'h00)) begin
                push_req  = 1'b1;
                push_data = {1'b1, scan_ts, 3'b000};
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ts        <= '0;
            scan_vec  <= '0;
            scan_ts   <= '0;
            idx       <= '0;
            pend_full <= 1'b0;
            pend_vec  <= '0;
            pend_ts   <= '0;
            step_lost <= 1'b0;
        end else begin
            if (strobe_ok) begin
                ts <= ts + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (strobe_ok) begin
                        state    <= SCAN;
                        idx      <= '0;
                        scan_vec <= spikes_in;
                        scan_ts  <= ts;
                    end
                end
                SCAN: begin
                    idx <= idx + 3'd1;
                    if (last_cycle) begin
                        if (pend_full) begin
                            scan_vec  <= pend_vec;
                            scan_ts   <= pend_ts;
                            pend_full <= strobe_ok;
                            if (strobe_ok) begin
                                pend_vec <= spikes_in;
                                pend_ts  <= ts;
                            end
                        end else if (strobe_ok) begin
                            scan_vec <= spikes_in;
                            scan_ts  <= ts;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (strobe_ok && !pend_full) begin
                        pend_full <= 1'b1;
                        pend_vec  <= spikes_in;
                        pend_ts   <= ts;
                    end
                end
                default: state <= IDLE;
            endcase
            step_lost <= lost_set | (step_lost & ~clear_flags);
        end
    end

    // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
    assign pop          = out_valid & out_ready;
    assign full         = (count == CW'(FIFO_DEPTH));
    assign push_ok      = push_req & (~full | pop);
    assign overflow_set = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow <= overflow_set | (overflow & ~clear_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : 12'h000;
    assign fifo_count = count;
    assign busy       = (state == SCAN) | pend_full;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Self-checking bench for spike_event_encoder: a timestep scheduling model plus directed vectors.
// Honours SPIKE_ENC_EMPTY_STEP_EN when the same macro is defined for the build.
module tb_spike_event_encoder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        step_strobe;
    logic [7:0]  spikes_in;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fifo_count;
    logic        busy;
    logic        overflow;
    logic        step_lost;
    logic        clear_flags;

    int compared   = 0;
    int mismatched = 0;

    // Model state: each scanned record is just its start edge; words are pre-placed at the edge that pushes them.
    int          cyc = 0;
    bit          model_on = 0;
    logic [11:0] m_fifo[$];
    logic [11:0] push_at[int];
    int          rec_starts[$];
    logic [7:0]  m_ts;
    bit          m_ovf;
    bit          m_lost;
    bit          m_pop;
    bit          m_ovf_set;
    bit          m_lost_set;
    int          occ;
    int          last_end;

    logic [11:0] drained[$];
    int          busy_cnt;

    spike_event_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .step_strobe (step_strobe),
        .spikes_in   (spikes_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .overflow    (overflow),
        .step_lost   (step_lost),
        .clear_flags (clear_flags)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic void schedule(input int s, input logic [7:0] v, input logic [7:0] t);
        rec_starts.push_back(s);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) push_at[s + 1 + i] = {1'b0, t, 3'(i)};
        end
`ifdef SPIKE_ENC_EMPTY_STEP_EN
        if (v == 8'h00) push_at[s + 8] = {1'b1, t, 3'b000};
`endif
    endfunction

    function automatic int model_busy();
        foreach (rec_starts[i]) begin
            if (rec_starts[i] <= cyc && cyc < rec_starts[i] + 8) return 1;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            model_on = 1;
            m_fifo.delete();
            push_at.delete();
            rec_starts.delete();
            m_ts   = 8'd0;
            m_ovf  = 0;
            m_lost = 0;
        end else if (model_on) begin
            m_pop      = (m_fifo.size() > 0) && out_ready;
            m_ovf_set  = 0;
            m_lost_set = 0;
            if (step_strobe && enable) begin
                occ      = 0;
                last_end = 0;
                foreach (rec_starts[i]) begin
                    if (rec_starts[i] + 8 > cyc) begin
                        occ++;
                        if (rec_starts[i] + 8 > last_end) last_end = rec_starts[i] + 8;
                    end
                end
                if (occ == 0)      schedule(cyc, spikes_in, m_ts);
                else if (occ == 1) schedule(last_end, spikes_in, m_ts);
                else               m_lost_set = 1;
                m_ts = m_ts + 8'd1;
            end
            if (m_pop) m_fifo.delete(0);
            if (push_at.exists(cyc)) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(push_at[cyc]);
                else                       m_ovf_set = 1;
            end
            m_ovf  = m_ovf_set  | (m_ovf  & !clear_flags);
            m_lost = m_lost_set | (m_lost & !clear_flags);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check_output("out_valid", int'(out_valid), int'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) check_output("out_data", int'(out_data), int'(m_fifo[0]));
            check_output("fifo_count", int'(fifo_count), m_fifo.size());
            check_output("busy", int'(busy), model_busy());
            check_output("overflow", int'(overflow), int'(m_ovf));
            check_output("step_lost", int'(step_lost), int'(m_lost));
            if (out_valid && out_ready) drained.push_back(out_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] vec);
        step_strobe = 1'b1;
        spikes_in   = vec;
        tick(1);
        step_strobe = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        step_strobe = 1'b0;
        spikes_in   = 8'h00;
        out_ready   = 1'b0;
        clear_flags = 1'b0;
        tick(3);

        check_output("reset_out_valid", int'(out_valid), 0);
        check_output("reset_out_data", int'(out_data), 0);
        check_output("reset_fifo_count", int'(fifo_count), 0);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_overflow", int'(overflow), 0);
        check_output("reset_step_lost", int'(step_lost), 0);

        // Basic three-event step
        reset     = 1'b0;
        out_ready = 1'b1;
        tick(1);
        drained.delete();
        apply_stimulus(8'b1000_0101);
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) busy_cnt++;
            tick(1);
        end
        tick(4);
        check_output("basic_busy_cycles", busy_cnt, 8);
        check_output("basic_word_count", drained.size(), 3);
        if (drained.size() == 3) begin
            check_output("basic_word0", int'(drained[0]), 'h000);
            check_output("basic_word1", int'(drained[1]), 'h002);
            check_output("basic_word2", int'(drained[2]), 'h007);
        end
        check_output("basic_fifo_empty", int'(fifo_count), 0);

        // Timestep wrap over 257 strobes
        pulse_reset();
        drained.delete();
        for (int j = 0; j < 257; j++) begin
            apply_stimulus(8'h01);
            tick(9);
        end
        tick(5);
        check_output("wrap_word_count", drained.size(), 257);
        for (int j = 0; j < drained.size() && j < 257; j++) begin
            check_output("wrap_word", int'(drained[j]), (j % 256) << 3);
        end
        if (drained.size() == 257) begin
            check_output("wrap_ts255", int'(drained[255]), 'h7F8);
            check_output("wrap_ts0", int'(drained[256]), 'h000);
        end

        // Overflow with a stalled consumer
        pulse_reset();
        out_ready = 1'b0;
        drained.delete();
        apply_stimulus(8'hFF);
        tick(7);
        apply_stimulus(8'hFF);
        tick(7);
        apply_stimulus(8'hFF);
        tick(12);
        check_output("ovf_fifo_full", int'(fifo_count), 16);
        check_output("ovf_flag_set", int'(overflow), 1);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check_output("ovf_flag_cleared", int'(overflow), 0);
        out_ready = 1'b1;
        tick(20);
        check_output("ovf_drain_count", drained.size(), 16);
        for (int i = 0; i < drained.size() && i < 16; i++) begin
            check_output("ovf_drain_word", int'(drained[i]), ((i / 8) << 3) | (i % 8));
        end

        // Pending slot and lost step
        pulse_reset();
        drained.delete();
        apply_stimulus(8'h01);
        tick(1);
        apply_stimulus(8'h02);
        tick(1);
        apply_stimulus(8'h04);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            tick(1);
        end
        check_output("lost_busy_tail", busy_cnt, 12);
        check_output("lost_flag", int'(step_lost), 1);
        apply_stimulus(8'h08);
        tick(12);
        check_output("lost_word_count", drained.size(), 3);
        if (drained.size() == 3) begin
            check_output("lost_word0", int'(drained[0]), 'h000);
            check_output("lost_word1", int'(drained[1]), 'h009);
            check_output("lost_word2", int'(drained[2]), 'h01B);
        end
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check_output("lost_flag_cleared", int'(step_lost), 0);

        // Empty timestep
        pulse_reset();
        drained.delete();
        apply_stimulus(8'h00);
        tick(12);
`ifdef SPIKE_ENC_EMPTY_STEP_EN
        check_output("empty_word_count", drained.size(), 1);
        if (drained.size() == 1) check_output("empty_marker", int'(drained[0]), 'h800);
`else
        check_output("empty_word_count", drained.size(), 0);
`endif

        // Reset mid-scan, then strobes ignored while disabled
        out_ready = 1'b0;
        apply_stimulus(8'hFF);
        tick(3);
        reset = 1'b1;
        tick(1);
        check_output("midreset_out_valid", int'(out_valid), 0);
        check_output("midreset_fifo_count", int'(fifo_count), 0);
        check_output("midreset_busy", int'(busy), 0);
        reset  = 1'b0;
        enable = 1'b0;
        apply_stimulus(8'hFF);
        tick(10);
        check_output("disabled_fifo_count", int'(fifo_count), 0);
        enable    = 1'b1;
        out_ready = 1'b1;
        drained.delete();
        apply_stimulus(8'h01);
        tick(12);
        check_output("post_reset_count", drained.size(), 1);
        if (drained.size() == 1) check_output("post_reset_ts0", int'(drained[0]), 'h000);

        // Mixed traffic with a stuttering consumer; the per-cycle model does the checking
        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            out_ready   = 1'($urandom_range(0, 1));
            clear_flags = ($urandom_range(0, 15) == 0);
            step_strobe = (i % 5 == 0);
            spikes_in   = 8'($urandom);
            tick(1);
        end
        step_strobe = 1'b0;
        clear_flags = 1'b0;
        out_ready   = 1'b1;
        tick(30);
        check_output("final_fifo_empty", int'(fifo_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
